// File: rtl/cnt_mon_pkg.sv
// Shared types for the counter delta monitor: counter word, change record, tracking state.
// No logic here; the records are produced by cnt_delta_mon and queued in cnt_mon_fifo.
package cnt_mon_pkg;

    localparam int CNT_W  = 5;
    localparam int DROP_W = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t cnt;
        cnt_t delta;
    } rec_t;

    typedef enum logic {
        IDLE,
        TRACK
    } mon_state_e;

endpackage

// File: rtl/cnt_mon_fifo.sv
// Record FIFO for the delta monitor; head is registered storage, zero when empty.
// Latency: push at edge N is visible at the head after edge N when empty.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module cnt_mon_fifo
    import cnt_mon_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  rec_t             push_dat_i,
    input  logic             pop_i,
    output rec_t             head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    rec_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign do_pop  = pop_i && !empty_o;
    // When full, the slot being written is the one being popped this cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/cnt_delta_mon.sv
// Counter delta monitor: wrap-aware increments, saturating total, change-record queue.
// Latency: sample at edge N updates acc and (if empty) the head record after edge N.
// Backpressure: records arriving at a full queue without a pop are dropped and counted.
module cnt_delta_mon
    import cnt_mon_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ACC_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CNT_W-1:0]         cnt_in,
    input  logic                     in_en,
    input  logic                     clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         out_cnt,
    output logic [CNT_W-1:0]         out_delta,
    output logic [ACC_W-1:0]         acc,
    output logic                     acc_sat,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    mon_state_e        state_q;
    cnt_t              ref_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              acc_sat_q, acc_sat_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    cnt_t              delta;
    logic [ACC_W:0]    acc_sum;
    logic              chg;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    rec_t              head;

    assign delta   = cnt_in - ref_q;
    assign chg     = in_en && (state_q == TRACK) && (delta != '0);
    assign pop     = out_valid && out_ready && !clr;
    assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(delta);

    always_comb begin
        acc_d     = acc_q;
        acc_sat_d = acc_sat_q;
        drop_d    = drop_q;
        if (chg) begin
            if (acc_sum[ACC_W]) begin
                acc_d     = '1;
                acc_sat_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_W-1:0];
            end
            if (fifo_full && !pop && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ref_q     <= '0;
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
            drop_q    <= '0;
        end else if (clr) begin
            state_q   <= IDLE;
            ref_q     <= '0;
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            if (in_en) begin
                ref_q   <= cnt_in;
                state_q <= TRACK;
            end
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
            drop_q    <= drop_d;
        end
    end

    cnt_mon_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (clr),
        .push_i     (chg && !clr),
        .push_dat_i ('{cnt: cnt_in, delta: delta}),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (level)
    );

    assign out_valid = !fifo_empty;
    assign out_cnt   = head.cnt;
    assign out_delta = head.delta;
    assign acc       = acc_q;
    assign acc_sat   = acc_sat_q;
    assign drop_cnt  = drop_q;

endmodule

// File: doc/cnt_delta_mon.md
# cnt_delta_mon

Downstream monitor for the 5-bit event counter value `x`. Samples the counter each enabled cycle and computes the wrap-aware increment since the previous sample. Accumulates increments into a wide saturating total and queues one change record per nonzero increment in a small FIFO, drained via valid/ready. Sits between the counter stage and the status/readout logic.

## Interface
- `DEPTH`, 4: record FIFO depth, power of two, ≥2
- `ACC_W`, 16: accumulator width, ≥6
- `clk` input 1: single clock, all state on rising edge
- `rst_n` input 1: reset, asynchronous and active-low
- `cnt_in` input 5: counter value from upstream stage
- `in_en` input 1: sample `cnt_in` this cycle
- `clr` input 1: synchronous clear of all monitor state
- `out_valid` output 1: FIFO head holds a record
- `out_ready` input 1: consumer accepts head record
- `out_cnt` output 5: record: sampled counter value
- `out_delta` output 5: record: increment, mod 32
- `acc` output ACC_W: saturating sum of all deltas
- `acc_sat` output 1: sticky, `acc` has saturated
- `drop_cnt` output 8: saturating count of records lost to a full FIFO
- `level` output $clog2(DEPTH)+1: FIFO occupancy

## Operation
- FSM states: IDLE (no reference value held), TRACK (reference `ref` valid).
- IDLE, `in_en`=1: `ref`<=`cnt_in`, go to TRACK; no record pushed, `acc` unchanged.
- TRACK, `in_en`=1: `delta` = (`cnt_in` - `ref`) mod 32, 5-bit unsigned; `ref`<=`cnt_in`.
  - `delta`==0: no push, no `acc` change.
  - `delta`!=0: push {`cnt_in`, `delta`}; `acc`<=min(`acc`+`delta`, 2^ACC_W-1); `acc_sat` set when clamping occurs.
- Wrap: 31 -> 2 gives `delta`=3. A full cycle back to the same value is indistinguishable from no change (`delta`=0, by design).
- FIFO full with no pop in the same cycle: the push is dropped, `drop_cnt`+1 (saturates at 255), and `acc` is still updated.
- Full with a pop in the same cycle: the push succeeds and `level` stays at DEPTH.
- Pop: `out_valid && out_ready`. `out_ready` while empty has no effect.
- `clr`=1: FSM -> IDLE; FIFO flushed; `acc`, `acc_sat`, `drop_cnt` <= 0. `clr` beats a simultaneous `in_en` and pop.
- `in_en`=0: all state holds except FIFO pops.

## Timing
- Reset (`rst_n`=0, async): state IDLE, `ref`=0, `level`=0, `out_valid`=0, `out_cnt`=0, `out_delta`=0, `acc`=0, `acc_sat`=0, `drop_cnt`=0. Reset mid-operation discards queued records immediately.
- Push latency: sample at edge N -> `out_valid`=1 and record on `out_cnt`/`out_delta` after edge N (empty FIFO case); `acc` also updates after edge N.
- Head outputs come straight from registers, with no combinational path from `cnt_in`/`in_en`.
- `out_valid` has no combinational dependence on `out_ready`.
- Head must hold stable while `out_valid && !out_ready`.
- Sustained throughput: one push and one pop per cycle.
- `out_cnt`/`out_delta` are 0 when empty.

## Structure
- Package `cnt_mon_pkg`:
  - `CNT_W`=5
  - `cnt_t` (logic [4:0])
  - `rec_t` struct {cnt, delta}
  - `mon_state_e` {IDLE, TRACK}
- Sub-module `cnt_mon_fifo`: DEPTH-entry synchronous FIFO of `rec_t`.
  - Ports: push/pop, full/empty, level, flush.
  - Behaviour: push-when-full-with-pop allowed; async active-low reset.
- Top level: FSM, delta subtractor, saturating accumulator, drop counter.

## Test plan
- Reset, then samples 7 (IDLE), 7, 10 -> one record {10,3}, `acc`=3, `level`=1.
- Wrap: reference 30, sample 1 -> record {1,3}; sample 1 again -> no record.
- `out_ready`=0, 6 distinct changes with DEPTH=4 -> `level`=4, `drop_cnt`=2, `acc`=sum of all 6 deltas; drain yields the first 4 records in order.
- Full FIFO, push and pop in the same cycle -> `level` stays 4, new record present at tail, `drop_cnt` unchanged.
- ACC_W=6, deltas 31+31+5 -> `acc`=63, `acc_sat`=1.
- `clr` asserted with `in_en` and `out_ready` while `level`=3 -> next cycle IDLE, `level`=0, counters 0, next sample only re-captures `ref`. Repeat with `rst_n` pulsed between clock edges -> outputs 0 before the next edge.
